esn_sram_arbiter: RTL and testbench

//  Shares one single-port weight/state SRAM between the off-chip host loader and the ESN compute

---
 rtl/esn_sram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_esn_sram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esn_sram_arbiter.sv
// Shares one single-port SRAM between the host loader and the ESN compute engine.
// The grant policy depends on the system mode. Read data is returned to its issuer through a tag pipeline.
module esn_sram_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [1:0]        SRAM_State,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              eng_req,
    input  logic [ADDR_W-1:0] eng_addr,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,
    output logic              sram_cs_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'b00,
        MODE_LOAD    = 2'b01,
        MODE_COMPUTE = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    typedef enum logic {ST_ARB = 1'b0, ST_DRAIN = 1'b1} state_t;
    typedef enum logic {OWN_HOST = 1'b0, OWN_ENG = 1'b1} owner_t;

    localparam int               CNT_W      = $clog2(RD_LAT + 2);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(RD_LAT + 1);

    state_t              r_state;
    mode_t               r_mode_q;
    owner_t              r_rr_last;
    logic [CNT_W-1:0]    r_drain_cnt;
    logic [RD_LAT:0]     r_tag_vld;
    logic [RD_LAT:0]     r_tag_eng;
    logic                r_cs_n;
    logic                r_we_n;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_host_rvalid;
    logic [DATA_W-1:0]   r_host_rdata;
    logic                r_eng_rvalid;
    logic [DATA_W-1:0]   r_eng_rdata;
    logic [15:0]         r_conflict_cnt;

    logic                w_host_gnt;
    logic                w_eng_gnt;
    logic                w_mode_change;
    logic                w_rd_accept;
    logic                w_ret_vld;
    logic                w_ret_eng;

    assign w_mode_change = (SRAM_State != r_mode_q);
    assign w_rd_accept   = w_eng_gnt | (w_host_gnt & ~host_we);
    assign w_ret_vld     = r_tag_vld[RD_LAT];
    assign w_ret_eng     = r_tag_eng[RD_LAT];

    // Grants are gated by nrst so nothing is offered while the block is held in reset.
    always_comb begin
        // NOTE: default every output first so no path through the case infers a latch.
        w_host_gnt = 1'b0;
        w_eng_gnt  = 1'b0;
        if (nrst && r_state == ST_ARB) begin
            case (r_mode_q)
                MODE_IDLE: begin
                    if (host_req && eng_req) begin
                        w_host_gnt = (r_rr_last == OWN_ENG);
                        w_eng_gnt  = (r_rr_last == OWN_HOST);
                    end else begin
                        w_host_gnt = host_req;
                        w_eng_gnt  = eng_req;
                    end
                end
                MODE_LOAD: begin
                    w_host_gnt = host_req;
                    w_eng_gnt  = eng_req & ~host_req;
                end
                MODE_COMPUTE: begin
                    w_eng_gnt  = eng_req;
                    w_host_gnt = host_req & ~eng_req;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (!nrst) begin
            r_state        <= ST_ARB;
            r_mode_q       <= MODE_IDLE;
            r_rr_last      <= OWN_ENG;
            r_drain_cnt    <= '0;
            r_tag_vld      <= '0;
            r_tag_eng      <= '0;
            r_cs_n         <= 1'b1;
            r_we_n         <= 1'b1;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_host_rvalid  <= 1'b0;
            r_host_rdata   <= '0;
            r_eng_rvalid   <= 1'b0;
            r_eng_rdata    <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_mode_q <= mode_t'(SRAM_State);

            case (r_state)
                ST_ARB: begin
                    if (w_mode_change) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DRAIN_LOAD;
                    end
                end
                default: begin
                    if (w_mode_change) begin
                        r_drain_cnt <= DRAIN_LOAD;
                    end else if (r_drain_cnt == '0) begin
                        r_state <= ST_ARB;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - CNT_W'(1);
                    end
                end
            endcase

            if (w_host_gnt) begin
                r_rr_last <= OWN_HOST;
            end else if (w_eng_gnt) begin
                r_rr_last <= OWN_ENG;
            end

            r_cs_n <= ~(w_host_gnt | w_eng_gnt);
            r_we_n <= w_host_gnt ? ~host_we : 1'b1;
            if (w_host_gnt) begin
                r_addr  <= host_addr;
                r_wdata <= host_wdata;
            end else if (w_eng_gnt) begin
                r_addr <= eng_addr;
            end

            // Stage 0 captures the accept; the last stage lines up with the SRAM data.
            r_tag_vld <= {r_tag_vld[RD_LAT-1:0], w_rd_accept};
            r_tag_eng <= {r_tag_eng[RD_LAT-1:0], w_eng_gnt};

            r_host_rvalid <= w_ret_vld & ~w_ret_eng;
            r_eng_rvalid  <= w_ret_vld & w_ret_eng;
            if (w_ret_vld && !w_ret_eng) begin
                r_host_rdata <= sram_rdata;
            end
            if (w_ret_vld && w_ret_eng) begin
                r_eng_rdata <= sram_rdata;
            end

            if (r_state == ST_ARB && w_mode_change && SRAM_State == MODE_COMPUTE) begin
                r_conflict_cnt <= '0;
            end else if (eng_req && !w_eng_gnt && r_conflict_cnt != 16'hFFFF) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign host_gnt     = w_host_gnt;
    assign eng_gnt      = w_eng_gnt;
    assign host_rvalid  = r_host_rvalid;
    assign host_rdata   = r_host_rdata;
    assign eng_rvalid   = r_eng_rvalid;
    assign eng_rdata    = r_eng_rdata;
    assign sram_cs_n    = r_cs_n;
    assign sram_we_n    = r_we_n;
    assign sram_addr    = r_addr;
    assign sram_wdata   = r_wdata;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_esn_sram_arbiter.sv
// Directed bench for esn_sram_arbiter with a latency-1 synchronous SRAM model.
// Read data is checked against per-requester queues of expected words.
module tb_esn_sram_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 1;

    logic              clk;
    logic              nrst;
    logic [1:0]        SRAM_State;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              eng_req;
    logic [ADDR_W-1:0] eng_addr;
    logic              eng_gnt;
    logic              eng_rvalid;
    logic [DATA_W-1:0] eng_rdata;
    logic              sram_cs_n;
    logic              sram_we_n;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic [15:0]       conflict_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_eng_rv = 0;
    int n_host_rv = 0;

    logic [15:0] eng_exp[$];
    logic [15:0] host_exp[$];

    bit [15:0] mem_w  [1024];
    bit        mem_wr [1024];

    esn_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .nrst(nrst), .SRAM_State(SRAM_State),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .eng_req(eng_req), .eng_addr(eng_addr), .eng_gnt(eng_gnt),
        .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations read back a fixed pattern derived from the address.
    function automatic logic [15:0] init_word(input logic [ADDR_W-1:0] a);
        return 16'hC000 | {6'd0, a[9:0]};
    endfunction

    always @(posedge clk) begin
        if (!sram_cs_n) begin
            if (!sram_we_n) begin
                mem_w[sram_addr[9:0]]  <= sram_wdata;
                mem_wr[sram_addr[9:0]] <= 1'b1;
            end else begin
                sram_rdata <= mem_wr[sram_addr[9:0]] ? mem_w[sram_addr[9:0]] : init_word(sram_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (eng_rvalid === 1'b1) begin
            n_eng_rv++;
            if (eng_exp.size() == 0) check("eng_spurious_rvalid", 1, 0);
            else check("eng_rdata", eng_rdata, eng_exp.pop_front());
        end
        if (host_rvalid === 1'b1) begin
            n_host_rv++;
            if (host_exp.size() == 0) check("host_spurious_rvalid", 1, 0);
            else check("host_rdata", host_rdata, host_exp.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        nrst = 1'b0;
        host_req = 1'b0;
        eng_req = 1'b0;
        host_we = 1'b0;
        eng_exp.delete();
        host_exp.delete();
        next_cycle();
        nrst = 1'b1;
    endtask

    initial begin
        int g;
        int h;
        int rv0;

        nrst = 1'b0; SRAM_State = 2'b00;
        host_req = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        eng_req = 1'b1; eng_addr = '0;

        // 1: reset with both requests high
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            at_sample();
            check("t1_host_gnt", host_gnt, 0);
            check("t1_eng_gnt", eng_gnt, 0);
            check("t1_host_rvalid", host_rvalid, 0);
            check("t1_eng_rvalid", eng_rvalid, 0);
            check("t1_cs_n", sram_cs_n, 1);
            check("t1_we_n", sram_we_n, 1);
            check("t1_addr", sram_addr, 0);
            check("t1_wdata", sram_wdata, 0);
            check("t1_cnt", conflict_cnt, 0);
        end
        next_cycle();
        nrst = 1'b1; host_req = 1'b0; eng_req = 1'b0;

        // 2: round-robin in idle mode, host wins the first tie
        for (int k = 0; k < 9; k++) begin
            host_req = (k < 6); host_we = 1'b0; host_addr = 20'h00010;
            eng_req = (k < 6); eng_addr = 20'h00020;
            at_sample();
            if (k < 6) begin
                check("t2_host_gnt", host_gnt, (k % 2 == 0));
                check("t2_eng_gnt", eng_gnt, (k % 2 == 1));
                if (k % 2 == 0) host_exp.push_back(init_word(20'h00010));
                else eng_exp.push_back(init_word(20'h00020));
            end
            check("t2_host_rvalid", host_rvalid, (k >= 3 && k <= 7 && k % 2 == 1));
            check("t2_eng_rvalid", eng_rvalid, (k >= 4 && k % 2 == 0));
            check("t2_cs_n", sram_cs_n, (k >= 1 && k <= 6) ? 0 : 1);
            if (k == 1) check("t2_addr_host", sram_addr, 20'h00010);
            if (k == 2) check("t2_addr_eng", sram_addr, 20'h00020);
            if (k == 6) check("t2_cnt", conflict_cnt, 3);
            next_cycle();
        end

        // 3: load mode, host writes beat the engine
        SRAM_State = 2'b01;
        apply_reset();
        repeat (5) next_cycle();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                host_req = 1'b1; host_we = 1'b1; host_addr = 20'(k); host_wdata = 16'h00A0 + 16'(k);
                eng_req = 1'b1; eng_addr = 20'h003FF;
            end else begin
                host_req = 1'b0; host_we = 1'b0; eng_req = 1'b0;
            end
            at_sample();
            if (k < 4) begin
                check("t3_host_gnt", host_gnt, 1);
                check("t3_eng_gnt", eng_gnt, 0);
            end
            if (k >= 1 && k <= 4) begin
                check("t3_cs_n", sram_cs_n, 0);
                check("t3_we_n", sram_we_n, 0);
                check("t3_addr", sram_addr, k - 1);
                check("t3_wdata", sram_wdata, 16'h00A0 + 16'(k - 1));
            end
            if (k == 4) check("t3_cnt", conflict_cnt, 4);
            if (k == 5) begin
                check("t3_idle_cs_n", sram_cs_n, 1);
                check("t3_idle_we_n", sram_we_n, 1);
                check("t3_addr_hold", sram_addr, 3);
            end
            next_cycle();
        end
        host_req = 1'b1; host_we = 1'b0; host_addr = 20'h00002;
        at_sample();
        check("t3_rd_gnt", host_gnt, 1);
        host_exp.push_back(16'h00A2);
        next_cycle();
        host_req = 1'b0;
        repeat (4) next_cycle();

        // 4: compute mode streaming, counter cleared on the switch
        SRAM_State = 2'b10;
        repeat (5) next_cycle();
        at_sample();
        check("t4_cnt_clear", conflict_cnt, 0);
        next_cycle();
        g = 0; h = 0; rv0 = n_eng_rv;
        for (int i = 0; i < 1000; i++) begin
            eng_req = 1'b1; eng_addr = 20'(8 + i);
            host_req = 1'b1; host_we = 1'b0; host_addr = 20'h00005;
            at_sample();
            if (eng_gnt) g++;
            if (host_gnt) h++;
            eng_exp.push_back(init_word(20'(8 + i)));
            next_cycle();
        end
        eng_req = 1'b0; host_req = 1'b0;
        repeat (4) next_cycle();
        at_sample();
        check("t4_eng_gnt_cycles", g, 1000);
        check("t4_host_gnt_cycles", h, 0);
        check("t4_eng_rvalid_count", n_eng_rv - rv0, 1000);
        check("t4_eng_queue_left", eng_exp.size(), 0);
        check("t4_host_queue_left", host_exp.size(), 0);
        next_cycle();

        // 5: 01 -> 10 switch with two host reads in flight
        SRAM_State = 2'b01;
        apply_reset();
        repeat (5) next_cycle();
        host_req = 1'b1; host_we = 1'b0; host_addr = 20'h00030; eng_req = 1'b0;
        at_sample();
        check("t5_gnt_a", host_gnt, 1);
        host_exp.push_back(init_word(20'h00030));
        next_cycle();
        host_addr = 20'h00031; SRAM_State = 2'b10;
        at_sample();
        check("t5_gnt_b", host_gnt, 1);
        host_exp.push_back(init_word(20'h00031));
        next_cycle();
        for (int d = 0; d < 3; d++) begin
            host_req = 1'b1; host_addr = 20'h00032; eng_req = 1'b1; eng_addr = 20'h00040;
            at_sample();
            check("t5_drain_host_gnt", host_gnt, 0);
            check("t5_drain_eng_gnt", eng_gnt, 0);
            check("t5_drain_host_rvalid", host_rvalid, (d >= 1));
            next_cycle();
        end
        at_sample();
        check("t5_eng_gnt", eng_gnt, 1);
        check("t5_host_gnt", host_gnt, 0);
        check("t5_cnt", conflict_cnt, 3);
        eng_exp.push_back(init_word(20'h00040));
        next_cycle();
        host_req = 1'b0; eng_req = 1'b0;
        repeat (4) next_cycle();
        at_sample();
        check("t5_host_queue_left", host_exp.size(), 0);
        check("t5_eng_queue_left", eng_exp.size(), 0);
        next_cycle();

        // 6: reset right after a read grant, then counter saturation
        rv0 = n_eng_rv;
        eng_req = 1'b1; eng_addr = 20'h00050;
        at_sample();
        check("t6_eng_gnt", eng_gnt, 1);
        next_cycle();
        nrst = 1'b0; eng_req = 1'b0; host_req = 1'b0; SRAM_State = 2'b11;
        at_sample();
        check("t6_gnt_in_reset", eng_gnt, 0);
        next_cycle();
        nrst = 1'b1;
        repeat (6) next_cycle();
        at_sample();
        check("t6_no_rvalid", n_eng_rv - rv0, 0);
        check("t6_cnt_reset", conflict_cnt, 0);
        next_cycle();
        eng_req = 1'b1;
        at_sample();
        check("t6_mode11_eng_gnt", eng_gnt, 0);
        next_cycle();
        repeat (65533) next_cycle();
        at_sample();
        check("t6_cnt_fffe", conflict_cnt, 16'hFFFE);
        next_cycle();
        at_sample();
        check("t6_cnt_sat", conflict_cnt, 16'hFFFF);
        next_cycle();
        at_sample();
        check("t6_cnt_hold", conflict_cnt, 16'hFFFF);
        next_cycle();
        eng_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
